audio_sample_gen: RTL and testbench

Parametrised audio source for the HDMI path: generates the audio sample clock from `clk_pixel` with an exact-average fractional divider and produces `CHANNELS` × `BIT_WIDTH` sample words.
- Samples come from one of four modes: mute, sawtooth, square tone, or a frame stream pushed by the MCU/AHB side through an internal FIFO.
- Sits between the pixel-clock domain logic and the `hdmi` core's `clk_audio` / `audio_sample_word` inputs.
- Replaces the fixed integer divider and hard-coded ramp test data.

---
 rtl/audio_gen_pkg.sv | 18 +
 rtl/audio_frame_fifo.sv | 72 +++++++
 rtl/audio_sample_gen.sv | 149 ++++++++++++++
 tb/tb_audio_sample_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_gen_pkg.sv
// Shared types and helpers for the audio sample generator.
//   audio_mode_e : sample source selection (mute, sawtooth, square, stream)
//   acc_width()  : width of the fractional divider accumulator
package audio_gen_pkg;

  typedef enum logic [1:0] {
    AUD_MUTE   = 2'd0,
    AUD_SAW    = 2'd1,
    AUD_SQUARE = 2'd2,
    AUD_STREAM = 2'd3
  } audio_mode_e;

  // The accumulator must hold acc + 2*rate before the wrap subtraction.
  function automatic int acc_width(input longint clk_hz, input longint audio_rate);
    return $clog2(clk_hz + 2 * audio_rate) + 1;
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO for the stream source.
//   clk_pixel, reset : clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data    : write request and frame (ignored when full)
//   pop              : read request (ignored when empty)
//   rd_data          : head frame, valid whenever !empty
//   full, empty      : status from the registered level
//   level            : frames held
module audio_frame_fifo
  import audio_gen_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_pixel,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_en, rd_en;

  always_comb begin
    full     = (level_q == LW'(DEPTH));
    empty    = (level_q == '0);
    wr_en    = push && !full;
    rd_en    = pop && !empty;
    rd_data  = mem_q[rd_ptr_q];
    level    = level_q;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    level_d = level_q + LW'(wr_en) - LW'(rd_en);
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk_pixel) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/audio_sample_gen.sv
// Audio sample source for the HDMI path: exact-average fractional divider
// producing clk_audio from clk_pixel, plus a per-sample frame generator.
//   clk_pixel, reset         : sole clock, synchronous active-high reset
//   mode                     : 0 mute, 1 sawtooth, 2 square, 3 stream
//   s_valid, s_data, s_ready : frame push interface into the stream FIFO
//   clk_audio, sample_strobe : 50 % sample clock and its rising-edge pulse
//   audio_sample_word        : current frame, channel 0 in the LSBs
//   fifo_level               : frames held in the stream FIFO
//   underrun_count           : saturating count of pops from an empty FIFO
module audio_sample_gen
  import audio_gen_pkg::*;
#(
  parameter int                   CLK_HZ         = 74_250_000,
  parameter int                   AUDIO_RATE     = 48000,
  parameter int                   BIT_WIDTH      = 16,
  parameter int                   CHANNELS       = 2,
  parameter logic [BIT_WIDTH-1:0] SAW_STEP       = 16'h1111,
  parameter int                   SQ_HALF_PERIOD = 24,
  parameter logic [BIT_WIDTH-1:0] SQ_AMPLITUDE   = 16'h4000,
  parameter int                   FIFO_DEPTH     = 8
) (
  input  logic                            clk_pixel,
  input  logic                            reset,
  input  logic [1:0]                      mode,
  input  logic                            s_valid,
  input  logic [CHANNELS*BIT_WIDTH-1:0]   s_data,
  output logic                            s_ready,
  output logic                            clk_audio,
  output logic                            sample_strobe,
  output logic [CHANNELS*BIT_WIDTH-1:0]   audio_sample_word,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     underrun_count
);

  localparam int FW = CHANNELS * BIT_WIDTH;
  localparam int AW = acc_width(CLK_HZ, AUDIO_RATE);
  localparam int CW = $clog2(SQ_HALF_PERIOD + 1);
  localparam logic [AW-1:0]        ACC_INC = AW'(2 * AUDIO_RATE);
  localparam logic [AW-1:0]        ACC_MOD = AW'(CLK_HZ);
  localparam logic [BIT_WIDTH-1:0] SQ_NEG  = ~SQ_AMPLITUDE + 1'b1;

  logic [AW-1:0]        acc_q, acc_d, acc_sum;
  logic                 tick, upd_tick, underrun;
  logic                 clk_audio_q, clk_audio_d, strobe_q, strobe_d;
  logic [FW-1:0]        word_q, word_d, frame_sel;
  logic [BIT_WIDTH-1:0] saw_q [CHANNELS];
  logic [BIT_WIDTH-1:0] saw_d [CHANNELS];
  logic [BIT_WIDTH-1:0] sq_level;
  logic [CW-1:0]        sq_cnt_q, sq_cnt_d;
  logic                 sq_phase_q, sq_phase_d;
  logic [15:0]          und_q, und_d;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]        fifo_head;
  audio_mode_e          mode_e;

  audio_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .push      (fifo_push),
    .wr_data   (s_data),
    .pop       (fifo_pop),
    .rd_data   (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    mode_e = audio_mode_e'(mode);

    // Adding 2*rate per cycle and wrapping at CLK_HZ yields ticks at exactly
    // twice the sample rate on average; clk_audio toggles on each tick.
    acc_sum     = acc_q + ACC_INC;
    tick        = (acc_sum >= ACC_MOD);
    acc_d       = tick ? (acc_sum - ACC_MOD) : acc_sum;
    upd_tick    = tick && clk_audio_q;
    clk_audio_d = tick ? ~clk_audio_q : clk_audio_q;
    strobe_d    = tick && !clk_audio_q;

    for (int c = 0; c < CHANNELS; c++) begin
      saw_d[c] = upd_tick ? saw_q[c] + BIT_WIDTH'(SAW_STEP * (c + 1)) : saw_q[c];
    end

    // Square output uses the phase held before this tick advances it.
    sq_cnt_d   = sq_cnt_q;
    sq_phase_d = sq_phase_q;
    if (upd_tick) begin
      if (sq_cnt_q == CW'(SQ_HALF_PERIOD - 1)) begin
        sq_cnt_d   = '0;
        sq_phase_d = ~sq_phase_q;
      end else begin
        sq_cnt_d = sq_cnt_q + 1'b1;
      end
    end
    sq_level = sq_phase_q ? SQ_NEG : SQ_AMPLITUDE;

    frame_sel = '0;
    case (mode_e)
      AUD_SAW: begin
        for (int c = 0; c < CHANNELS; c++) frame_sel[c*BIT_WIDTH +: BIT_WIDTH] = saw_d[c];
      end
      AUD_SQUARE: begin
        for (int c = 0; c < CHANNELS; c++) frame_sel[c*BIT_WIDTH +: BIT_WIDTH] = sq_level;
      end
      AUD_STREAM: frame_sel = fifo_empty ? '0 : fifo_head;
      default:    frame_sel = '0;
    endcase
    word_d = upd_tick ? frame_sel : word_q;

    // A push into an empty FIFO on an update tick still counts as an underrun;
    // the pushed frame is kept for the next tick.
    s_ready   = !fifo_full;
    fifo_push = s_valid && !fifo_full;
    fifo_pop  = upd_tick && (mode_e == AUD_STREAM) && !fifo_empty;
    underrun  = upd_tick && (mode_e == AUD_STREAM) && fifo_empty;
    und_d     = (underrun && (und_q != 16'hFFFF)) ? und_q + 16'd1 : und_q;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acc_q       <= '0;
      clk_audio_q <= 1'b0;
      strobe_q    <= 1'b0;
      word_q      <= '0;
      sq_cnt_q    <= '0;
      sq_phase_q  <= 1'b0;
      und_q       <= '0;
      for (int c = 0; c < CHANNELS; c++) saw_q[c] <= '0;
    end else begin
      acc_q       <= acc_d;
      clk_audio_q <= clk_audio_d;
      strobe_q    <= strobe_d;
      word_q      <= word_d;
      sq_cnt_q    <= sq_cnt_d;
      sq_phase_q  <= sq_phase_d;
      und_q       <= und_d;
      for (int c = 0; c < CHANNELS; c++) saw_q[c] <= saw_d[c];
    end
  end

  assign clk_audio         = clk_audio_q;
  assign sample_strobe     = strobe_q;
  assign audio_sample_word = word_q;
  assign underrun_count    = und_q;

endmodule

// File: tb/tb_audio_sample_gen.sv
module tb_audio_sample_gen;

  localparam int     M_CLK = 100;
  localparam int     M_AR  = 10;
  localparam int     HP    = 2;
  localparam int     DEPTH = 8;
  localparam longint D_CLK = 74_250_000;
  localparam longint D_AR  = 48000;
  localparam int     D_CYC = 50000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, s_valid, s_ready, clk_audio, sample_strobe;
  logic [1:0]  mode;
  logic [31:0] s_data, word;
  logic [3:0]  fifo_level;
  logic [15:0] underrun_count;

  audio_sample_gen #(
    .CLK_HZ(M_CLK), .AUDIO_RATE(M_AR), .SQ_HALF_PERIOD(HP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_pixel(clk), .reset(reset), .mode(mode), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .clk_audio(clk_audio), .sample_strobe(sample_strobe),
    .audio_sample_word(word), .fifo_level(fifo_level), .underrun_count(underrun_count)
  );

  logic        rst_def, s_valid_def, s_ready_def, clk_audio_def, strobe_def;
  logic [1:0]  mode_def;
  logic [31:0] s_data_def, word_def;
  logic [3:0]  level_def;
  logic [15:0] und_def;

  audio_sample_gen dut_def (
    .clk_pixel(clk), .reset(rst_def), .mode(mode_def), .s_valid(s_valid_def), .s_data(s_data_def),
    .s_ready(s_ready_def), .clk_audio(clk_audio_def), .sample_strobe(strobe_def),
    .audio_sample_word(word_def), .fifo_level(level_def), .underrun_count(und_def)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (state as seen after the most recent edge).
  longint      m_t;
  int          m_k, m_und;
  bit          m_clk, m_strobe, m_last_upd;
  logic [31:0] m_word;
  logic [31:0] m_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit tick_at(input longint t);
    return (((t + 1) * 2 * M_AR) / M_CLK) != ((t * 2 * M_AR) / M_CLK);
  endfunction

  function automatic bit upd_next();
    return tick_at(m_t) && m_clk;
  endfunction

  function automatic logic [31:0] saw_frame(input int k);
    logic [15:0] c0, c1;
    c0 = 16'(k * 32'h1111);
    c1 = 16'(k * 2 * 32'h1111);
    return {c1, c0};
  endfunction

  function automatic logic [31:0] sq_frame(input int k);
    logic [15:0] a;
    a = 16'h4000;
    if ((((k - 1) / HP) % 2) == 1) a = -a;
    return {a, a};
  endfunction

  task automatic model_reset();
    m_t = 0; m_k = 0; m_und = 0;
    m_clk = 0; m_strobe = 0; m_last_upd = 0;
    m_word = '0;
    m_q.delete();
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic step();
    bit tick, upd, ready;
    tick  = tick_at(m_t);
    ready = (m_q.size() < DEPTH);
    check("s_ready", s_ready, ready);
    upd = tick && m_clk;
    if (upd) begin
      m_k++;
      case (mode)
        2'd1:    m_word = saw_frame(m_k);
        2'd2:    m_word = sq_frame(m_k);
        2'd3: begin
          if (m_q.size() > 0) m_word = m_q.pop_front();
          else begin
            m_word = '0;
            if (m_und < 65535) m_und++;
          end
        end
        default: m_word = '0;
      endcase
    end
    if (s_valid && ready) m_q.push_back(s_data);
    m_strobe = tick && !m_clk;
    if (tick) m_clk = !m_clk;
    m_t++;
    m_last_upd = upd;
    @(posedge clk);
    #1;
    check("clk_audio", clk_audio, m_clk);
    check("sample_strobe", sample_strobe, m_strobe);
    check("audio_sample_word", word, m_word);
    check("fifo_level", fifo_level, m_q.size());
    check("underrun_count", underrun_count, m_und);
  endtask

  task automatic run_to_update();
    for (int i = 0; i < 30; i++) begin
      step();
      if (m_last_upd) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL run_to_update: no update tick within 30 cycles");
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("reset clk_audio", clk_audio, 0);
    check("reset sample_strobe", sample_strobe, 0);
    check("reset word", word, 0);
    check("reset fifo_level", fifo_level, 0);
    check("reset underrun", underrun_count, 0);
    check("reset s_ready", s_ready, 1);
    model_reset();
    reset = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    logic [1:0]  mode;
    int          skip;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] frames[3];
  int          rises, strobes;
  bit          prev;
  longint      d_ticks;

  initial begin
    vecs.push_back(vec_t'{1'b1, 2'd2, 0,  32'h4000_4000});
    vecs.push_back(vec_t'{1'b0, 2'd2, 0,  32'h4000_4000});
    vecs.push_back(vec_t'{1'b0, 2'd2, 0,  32'hC000_C000});
    vecs.push_back(vec_t'{1'b0, 2'd2, 0,  32'hC000_C000});
    vecs.push_back(vec_t'{1'b0, 2'd2, 0,  32'h4000_4000});
    vecs.push_back(vec_t'{1'b1, 2'd1, 0,  32'h2222_1111});
    vecs.push_back(vec_t'{1'b0, 2'd1, 0,  32'h4444_2222});
    vecs.push_back(vec_t'{1'b0, 2'd1, 0,  32'h6666_3333});
    vecs.push_back(vec_t'{1'b0, 2'd1, 11, 32'hFFFE_FFFF});
    vecs.push_back(vec_t'{1'b0, 2'd1, 0,  32'h2220_1110});
    vecs.push_back(vec_t'{1'b0, 2'd0, 0,  32'h0000_0000});
    frames[0] = 32'hAAAA_0001;
    frames[1] = 32'hBBBB_0002;
    frames[2] = 32'hCCCC_0003;

    reset = 1'b1; s_valid = 1'b0; s_data = '0; mode = 2'd0;
    rst_def = 1'b1; mode_def = 2'd0; s_valid_def = 1'b0; s_data_def = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Saw and square vectors
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      mode = vecs[i].mode;
      repeat (vecs[i].skip) run_to_update();
      run_to_update();
      check($sformatf("table[%0d] word", i), word, vecs[i].exp);
    end

    // Stream: three frames then an underrun
    do_reset();
    mode = 2'd3;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = frames[i];
      step();
    end
    s_valid = 1'b0;
    check("level after 3 pushes", fifo_level, 3);
    for (int i = 0; i < 4; i++) begin
      run_to_update();
      check($sformatf("stream word %0d", i), word, (i < 3) ? frames[i] : 32'h0);
    end
    check("underrun after drain", underrun_count, 1);

    // Fill to full, refused push, then pop head
    mode = 2'd0;
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1; s_data = 32'h1000_0000 + 32'(i);
      step();
    end
    s_data = 32'hDEAD_BEEF;
    check("s_ready when full", s_ready, 0);
    check("level when full", fifo_level, 8);
    step();
    check("level after refused push", fifo_level, 8);
    s_valid = 1'b0;
    mode = 2'd3;
    run_to_update();
    check("head after fill", word, 32'h1000_0000);
    check("level after pop", fifo_level, 7);

    // Reset mid-stream clears everything
    do_reset();

    // Push into empty FIFO on the update tick
    mode = 2'd3;
    for (int i = 0; i < 30 && !upd_next(); i++) step();
    s_valid = 1'b1; s_data = 32'h5A5A_A5A5;
    step();
    s_valid = 1'b0;
    check("same-cycle underrun", underrun_count, 1);
    check("same-cycle level", fifo_level, 1);
    check("same-cycle word", word, 0);
    run_to_update();
    check("same-cycle frame later", word, 32'h5A5A_A5A5);

    // Mode change 1 -> 3 mid-period
    do_reset();
    mode = 2'd1;
    run_to_update();
    check("pre-switch saw", word, 32'h2222_1111);
    repeat (3) step();
    mode = 2'd3;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_last_upd) break;
      check("word held after mode change", word, 32'h2222_1111);
    end
    check("word after mode switch", word, 0);
    check("underrun after mode switch", underrun_count, 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      s_valid = ($urandom_range(0, 7) == 0);
      s_data  = $urandom;
      step();
    end
    s_valid = 1'b0;

    // Default-rate divider: edge count over a fixed window
    rst_def = 1'b1;
    @(posedge clk);
    #1;
    rst_def = 1'b0;
    rises = 0; strobes = 0; prev = 1'b0;
    for (int i = 0; i < D_CYC; i++) begin
      @(posedge clk);
      #1;
      if (clk_audio_def && !prev) rises++;
      if (strobe_def) strobes++;
      prev = clk_audio_def;
    end
    d_ticks = (longint'(D_CYC) * 2 * D_AR) / D_CLK;
    check("default-rate rising edges", rises, (d_ticks + 1) / 2);
    check("default-rate strobes", strobes, (d_ticks + 1) / 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
